// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, flag bits
// and the per-operation tag carried alongside the ALU latency.
package alu_arb_pkg;

    localparam logic [3:0] INCA    = 4'd0;
    localparam logic [3:0] DECA    = 4'd1;
    localparam logic [3:0] ADD     = 4'd2;
    localparam logic [3:0] SUB     = 4'd3;
    localparam logic [3:0] ABS     = 4'd4;
    localparam logic [3:0] NEGA    = 4'd5;
    localparam logic [3:0] ILLEGAL = 4'd6;
    localparam logic [3:0] NEGB    = 4'd7;
    localparam logic [3:0] AND     = 4'd8;
    localparam logic [3:0] OR      = 4'd9;
    localparam logic [3:0] XOR     = 4'd10;
    localparam logic [3:0] INVB    = 4'd11;
    localparam logic [3:0] PASSA   = 4'd12;
    localparam logic [3:0] INVA    = 4'd13;
    localparam logic [3:0] ZEROES  = 4'd14;
    localparam logic [3:0] ONES    = 4'd15;

    localparam int FLAG_OVF   = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_ZERO  = 2;

    // Bit 3 of FLAGS is reserved and always returned as 0.
    localparam logic [3:0] FLAG_MASK = (4'b1 << FLAG_OVF) | (4'b1 << FLAG_CARRY)
                                     | (4'b1 << FLAG_ZERO);

    // Ownership record travelling with each issued operation.
    typedef struct packed {
        logic valid;
        logic owner;
        logic err;
    } tag_t;

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// requester not granted last wins. The pointer moves only on a grant.
module alu_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last;

    // Combinational one-hot grant; nothing is granted while reset is held.
    always_comb begin
        // NOTE: default assigned first so every path drives gnt and no latch is inferred.
        gnt = 2'b00;
        if (!rst) begin
            if (req[0] && (!req[1] || last)) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

    // LAST pointer: starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            last <= 1'b1;
        end else if (|gnt) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Arbiter and sequencer for the shared ALU: grants one request per cycle,
// tracks the owner of each in-flight operation through the ALU latency and
// returns the result to that owner. Opcode 6 is trapped with an error reply.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1     // 1..4 edges from ALU input latch to valid Z
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [3:0]       req0_inst,
    input  logic [3:0]       req1_inst,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_z,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_inst,
    input  logic [WIDTH-1:0] alu_z,
    input  logic [3:0]       alu_flags
);

    logic [1:0] gnt;
    logic [3:0] sel_inst;
    logic       issue_err;
    tag_t       tags [ALU_LAT+1];
    tag_t       tag_out;

    alu_rr_arbiter u_arb (
        .clk (clk),
        .rst (rst),
        .req ({req1_valid, req0_valid}),
        .gnt (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign tag_out    = tags[ALU_LAT];

    // Route the granted request to the ALU; an illegal opcode goes out as ZEROES.
    always_comb begin
        sel_inst = ZEROES;
        alu_a    = '0;
        alu_b    = '0;
        if (gnt[0]) begin
            sel_inst = req0_inst;
            alu_a    = req0_a;
            alu_b    = req0_b;
        end else if (gnt[1]) begin
            sel_inst = req1_inst;
            alu_a    = req1_a;
            alu_b    = req1_b;
        end
        issue_err = (|gnt) && (sel_inst == ILLEGAL);
        alu_inst  = issue_err ? ZEROES : sel_inst;
    end

    // Tag pipeline: one stage per edge, aligned so the last stage meets valid ALU_Z.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every stage is cleared because the valid bits decide whether a response fires.
            for (int i = 0; i <= ALU_LAT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            tags[0] <= '{valid: |gnt, owner: gnt[1], err: issue_err};
            for (int i = 1; i <= ALU_LAT; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    // Response registers: pulse the owner's valid, hold data between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_z      <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            rsp0_valid <= tag_out.valid && !tag_out.owner;
            rsp1_valid <= tag_out.valid && tag_out.owner;
            if (tag_out.valid) begin
                rsp_err   <= tag_out.err;
                rsp_z     <= tag_out.err ? '0 : alu_z;
                rsp_flags <= tag_out.err ? 4'h0 : (alu_flags & FLAG_MASK);
            end
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: a cycle table for the directed
// cases, a hand sequence for reset mid-flight, and a randomized run against
// a rule-level arbitration model and a response scoreboard. The bench also
// provides the behavioural ALU the arbiter drives.
module tb_alu_req_arbiter;
    import alu_arb_pkg::*;

    localparam int WIDTH   = 32;
    localparam int ALU_LAT = 1;
    localparam int N_RAND  = 1000;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [3:0]       req0_inst, req1_inst;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             rsp0_valid, rsp1_valid;
    logic [WIDTH-1:0] rsp_z;
    logic [3:0]       rsp_flags;
    logic             rsp_err;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_inst;
    logic [WIDTH-1:0] alu_z;
    logic [3:0]       alu_flags;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_req_arbiter #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_inst  (req0_inst),
        .req1_inst  (req1_inst),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_z      (rsp_z),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_inst   (alu_inst),
        .alu_z      (alu_z),
        .alu_flags  (alu_flags)
    );

    // ALU arithmetic: returns {flags, z}, flags = {0, zero, carry, ovf}.
    function automatic logic [35:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] x, y, z;
        logic        cin, arith, ovf, cy;
        x = a; y = 32'd0; cin = 1'b0; arith = 1'b1;
        case (op)
            INCA: cin = 1'b1;
            DECA: y = 32'hFFFF_FFFF;
            ADD:  y = b;
            SUB:  begin y = ~b; cin = 1'b1; end
            ABS:  if (a[31]) begin x = ~a; cin = 1'b1; end
            NEGA: begin x = ~a; cin = 1'b1; end
            NEGB: begin x = ~b; cin = 1'b1; end
            default: arith = 1'b0;
        endcase
        s = {1'b0, x} + {1'b0, y} + {32'd0, cin};
        if (arith) begin
            z   = s[31:0];
            ovf = (x[31] == y[31]) && (s[31] != x[31]);
            cy  = s[32];
        end else begin
            case (op)
                AND:     z = a & b;
                OR:      z = a | b;
                XOR:     z = a ^ b;
                INVB:    z = ~b;
                PASSA:   z = a;
                INVA:    z = ~a;
                ONES:    z = 32'hFFFF_FFFF;
                default: z = 32'd0;
            endcase
            ovf = 1'b0;
            cy  = 1'b0;
        end
        return {1'b0, (z == 32'd0), cy, ovf, z};
    endfunction

    // Behavioural ALU: inputs latched at an edge, result valid ALU_LAT edges later.
    logic [3:0]  in_inst_q;
    logic [31:0] in_a_q, in_b_q;
    logic [35:0] res_pipe [ALU_LAT];
    always @(posedge clk) begin
        in_inst_q   <= alu_inst;
        in_a_q      <= alu_a;
        in_b_q      <= alu_b;
        res_pipe[0] <= alu_ref(in_inst_q, in_a_q, in_b_q);
        for (int i = 1; i < ALU_LAT; i++) res_pipe[i] <= res_pipe[i-1];
    end
    assign alu_z     = res_pipe[ALU_LAT-1][31:0];
    assign alu_flags = res_pipe[ALU_LAT-1][35:32];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [3:0] i0, input logic [31:0] a0,
                         input logic [31:0] b0, input logic [3:0] i1, input logic [31:0] a1,
                         input logic [31:0] b1);
        req0_valid = v[0]; req0_inst = i0; req0_a = a0; req0_b = b0;
        req1_valid = v[1]; req1_inst = i1; req1_a = a1; req1_b = b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One row per cycle: stimulus, expected grant / ALU opcode / response pulse,
    // and optionally the response data under a flag mask.
    typedef struct {
        bit          rst;
        logic [1:0]  v;
        logic [3:0]  i0;
        logic [31:0] a0, b0;
        logic [3:0]  i1;
        logic [31:0] a1, b1;
        logic [1:0]  gnt;
        logic [3:0]  einst;
        logic [1:0]  rspv;
        bit          chk;
        logic [31:0] z;
        logic [3:0]  f, fm;
        bit          err;
    } vec_t;

    function automatic vec_t row(input bit r, input logic [1:0] v, input logic [3:0] i0,
                                 input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [3:0] i1, input logic [31:0] a1,
                                 input logic [31:0] b1, input logic [1:0] gnt,
                                 input logic [3:0] einst, input logic [1:0] rspv, input bit chk,
                                 input logic [31:0] z, input logic [3:0] f,
                                 input logic [3:0] fm, input bit err);
        vec_t t;
        t.rst = r; t.v = v; t.i0 = i0; t.a0 = a0; t.b0 = b0; t.i1 = i1; t.a1 = a1; t.b1 = b1;
        t.gnt = gnt; t.einst = einst; t.rspv = rspv; t.chk = chk; t.z = z; t.f = f;
        t.fm = fm; t.err = err;
        return t;
    endfunction

    typedef struct {
        int          due;
        bit          owner;
        logic [31:0] z;
        logic [3:0]  f;
        bit          err;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 3));
            1:       return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end by 2000000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          pv [2];
        logic [3:0]  pinst [2];
        logic [31:0] pa [2], pb [2];
        int          wait_cnt [2];
        bit          last_m;
        logic [1:0]  eg, rdy;
        logic [3:0]  e_inst;
        logic [31:0] held_z;
        logic [3:0]  held_f;
        bit          held_e;
        logic [35:0] r;
        exp_t        e;
        int          g;

        rst = 1'b1;
        drive(2'b00, 4'd0, 0, 0, 4'd0, 0, 0);
        next_cycle();

        // ---------------- directed table ----------------
        // 0: reset held with both valid: no grant, reset response values
        tbl.push_back(row(1, 2'b11, ADD, 5, 7, ADD, 1, 1, 2'b00, ZEROES, 2'b00, 1, 0, 0, 4'hF, 0));
        // 1..4: lone ADD 5+7 from REQ0, response two edges after acceptance
        tbl.push_back(row(0, 2'b01, ADD, 5, 7, 0, 0, 0, 2'b01, ADD, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, ZEROES, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, ZEROES, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, ZEROES, 2'b01, 1, 12, 0, 4'h4, 0));
        // 5: reset again so the contention run starts with LAST=1
        tbl.push_back(row(1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, ZEROES, 2'b00, 0, 0, 0, 0, 0));
        // 6..9: both valid, strict 0,1,0,1 alternation; REQ1 holds while waiting
        tbl.push_back(row(0, 2'b11, INCA, 0, 0, DECA, 1, 0, 2'b01, INCA, 2'b00, 1, 0, 0, 4'hF, 0));
        tbl.push_back(row(0, 2'b11, INCA, 1, 0, DECA, 1, 0, 2'b10, DECA, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 2'b11, INCA, 1, 0, DECA, 0, 0, 2'b01, INCA, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 2'b10, 0, 0, 0, DECA, 0, 0, 2'b10, DECA, 2'b01, 1, 1, 0, 4'h4, 0));
        // 10..12: remaining responses on consecutive cycles
        tbl.push_back(row(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, ZEROES, 2'b10, 1, 0, 4'h4, 4'h4, 0));
        tbl.push_back(row(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, ZEROES, 2'b01, 1, 2, 0, 4'h4, 0));
        tbl.push_back(row(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, ZEROES, 2'b10, 1, 32'hFFFF_FFFF, 0,
                          4'h4, 0));
        // 13..16: illegal opcode from REQ1, issued as ZEROES, error response
        tbl.push_back(row(0, 2'b10, 0, 0, 0, ILLEGAL, 32'h1234, 32'h1234, 2'b10, ZEROES, 2'b00, 0,
                          0, 0, 0, 0));
        tbl.push_back(row(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, ZEROES, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, ZEROES, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, ZEROES, 2'b10, 1, 0, 0, 4'hF, 1));
        // 17..21: SUB overflow then ABS; row 17 also checks the response hold
        tbl.push_back(row(0, 2'b01, SUB, 32'h8000_0000, 1, 0, 0, 0, 2'b01, SUB, 2'b00, 1, 0, 0,
                          4'hF, 1));
        tbl.push_back(row(0, 2'b01, ABS, 32'hFFFF_FFFD, 0, 0, 0, 0, 2'b01, ABS, 2'b00, 0, 0, 0, 0,
                          0));
        tbl.push_back(row(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, ZEROES, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, ZEROES, 2'b01, 1, 32'h7FFF_FFFF, 4'h1,
                          4'h1, 0));
        tbl.push_back(row(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, ZEROES, 2'b01, 1, 3, 4'h0, 4'h5, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            drive(tbl[i].v, tbl[i].i0, tbl[i].a0, tbl[i].b0, tbl[i].i1, tbl[i].a1, tbl[i].b1);
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), {req1_ready, req0_ready}, tbl[i].gnt);
            check($sformatf("vec%0d_alu_inst", i), alu_inst, tbl[i].einst);
            check($sformatf("vec%0d_rsp_valid", i), {rsp1_valid, rsp0_valid}, tbl[i].rspv);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d_rsp_z", i), rsp_z, tbl[i].z);
                check($sformatf("vec%0d_rsp_flags", i), rsp_flags & tbl[i].fm, tbl[i].f);
                check($sformatf("vec%0d_rsp_err", i), rsp_err, tbl[i].err);
            end
            next_cycle();
        end

        // ---------------- reset with an operation in flight ----------------
        drive(2'b01, ADD, 1, 1, 0, 0, 0);
        @(negedge clk);
        check("rstflt_accept", req0_ready, 1'b1);
        next_cycle();
        rst = 1'b1;
        drive(2'b01, ADD, 2, 2, 0, 0, 0);
        @(negedge clk);
        check("rstflt_ready_in_reset", {req1_ready, req0_ready}, 2'b00);
        check("rstflt_inst_in_reset", alu_inst, ZEROES);
        next_cycle();
        rst = 1'b0;
        drive(2'b11, INCA, 9, 0, DECA, 9, 0);
        @(negedge clk);
        check("rstflt_tie_after_reset", {req1_ready, req0_ready}, 2'b01);
        check("rstflt_no_rsp_a", {rsp1_valid, rsp0_valid}, 2'b00);
        next_cycle();
        drive(2'b10, 0, 0, 0, DECA, 9, 0);
        @(negedge clk);
        check("rstflt_second_grant", {req1_ready, req0_ready}, 2'b10);
        check("rstflt_discarded_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
        next_cycle();
        drive(2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rstflt_no_rsp_c", {rsp1_valid, rsp0_valid}, 2'b00);
        next_cycle();
        @(negedge clk);
        check("rstflt_rsp0", {rsp1_valid, rsp0_valid}, 2'b01);
        check("rstflt_rsp0_z", rsp_z, 32'd10);
        next_cycle();
        @(negedge clk);
        check("rstflt_rsp1", {rsp1_valid, rsp0_valid}, 2'b10);
        check("rstflt_rsp1_z", rsp_z, 32'd8);
        next_cycle();

        // ---------------- randomized run against the reference model ----------------
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        last_m = 1'b1;
        held_z = '0; held_f = '0; held_e = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pv[k] = 1'b0; pinst[k] = '0; pa[k] = '0; pb[k] = '0; wait_cnt[k] = 0;
        end

        for (int cyc = 0; cyc < N_RAND + ALU_LAT + 4; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pv[k]) begin
                    pv[k]    = (cyc < N_RAND) && ($urandom_range(0, 99) < 65);
                    pinst[k] = 4'($urandom_range(0, 15));
                    pa[k]    = rnd_operand();
                    pb[k]    = rnd_operand();
                end
            end
            drive({pv[1], pv[0]}, pinst[0], pa[0], pb[0], pinst[1], pa[1], pb[1]);
            @(negedge clk);

            // Arbitration rule: lone requester wins, tie goes to the one not granted last.
            if (pv[0] && pv[1])  eg = last_m ? 2'b01 : 2'b10;
            else if (pv[0])      eg = 2'b01;
            else if (pv[1])      eg = 2'b10;
            else                 eg = 2'b00;
            rdy = {req1_ready, req0_ready};
            check("rnd_ready", rdy, eg);

            if (eg != 2'b00) begin
                g = eg[1] ? 1 : 0;
                e_inst = (pinst[g] == ILLEGAL) ? ZEROES : pinst[g];
                check("rnd_alu_inst", alu_inst, e_inst);
                if (pinst[g] != ILLEGAL) check("rnd_alu_a", alu_a, pa[g]);
            end else begin
                check("rnd_alu_idle", {alu_inst, alu_a}, {ZEROES, 32'd0});
            end

            // Responses must come out exactly when due, in issue order, to the owner.
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("rnd_rsp_valid", {rsp1_valid, rsp0_valid}, e.owner ? 2'b10 : 2'b01);
                check("rnd_rsp_data", {rsp_err, rsp_flags, rsp_z}, {e.err, e.f, e.z});
                held_z = e.z; held_f = e.f; held_e = e.err;
            end else begin
                check("rnd_rsp_idle", {rsp1_valid, rsp0_valid}, 2'b00);
                check("rnd_rsp_hold", {rsp_err, rsp_flags, rsp_z}, {held_e, held_f, held_z});
            end

            for (int k = 0; k < 2; k++) begin
                if (pv[k] && !rdy[k]) wait_cnt[k]++;
                else                  wait_cnt[k] = 0;
                if (pv[k]) check($sformatf("rnd_starve%0d", k), 1'(wait_cnt[k] > 1), 1'b0);
            end

            if (eg != 2'b00) begin
                g = eg[1] ? 1 : 0;
                e.due   = cyc + ALU_LAT + 2;
                e.owner = eg[1];
                e.err   = (pinst[g] == ILLEGAL);
                if (e.err) begin
                    e.z = '0;
                    e.f = '0;
                end else begin
                    r   = alu_ref(pinst[g], pa[g], pb[g]);
                    e.z = r[31:0];
                    e.f = r[35:32];
                end
                sb.push_back(e);
                last_m = eg[1];
                pv[g]  = 1'b0;
            end
            next_cycle();
        end
        check("rnd_all_responses_seen", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
